// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: boots the PC, fetches one word per
// instruction, hands it to decode and resolves the next PC.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        exc_align,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT, REQ, ISSUE, RESOLVE
  } state_t;

  state_t      state, state_n;
  logic [31:0] tgt;
  logic        redir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= BOOT;
      instr   <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == REQ && imem_ack)
        instr <= imem_rdata;
      if (state == RESOLVE && !stall)
        retired <= retired + 32'd1;
    end
  end

  always_comb begin
    redir = 1'b0;
    tgt   = pc_cur + 32'd4;
    unique case (1'b1)
      jump: begin
        redir = 1'b1;
        tgt   = jump_target;
      end
      (!jump && branch_taken): begin
        redir = 1'b1;
        tgt   = branch_target;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    pc_next     = '0;
    pc_we       = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    exc_align   = 1'b0;
    case (state)
      BOOT: begin
        pc_we   = 1'b1;
        pc_next = RESET_VECTOR;
        state_n = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (imem_ack)
          state_n = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready)
          state_n = RESOLVE;
      end
      RESOLVE: begin
        if (!stall) begin
          pc_we   = 1'b1;
          pc_next = tgt;
          state_n = REQ;
          if (redir && tgt[1:0] != 2'b00) begin
            pc_next   = EXC_VECTOR;
            exc_align = 1'b1;
          end
        end
      end
      default: state_n = BOOT;
    endcase
    // BOOT is held while reset is low; no PC write may escape then
    if (!reset) begin
      pc_we   = 1'b0;
      pc_next = '0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_align;
  logic [31:0] retired;

  fetch_sequencer #(
    .RESET_VECTOR(RV),
    .EXC_VECTOR  (EXC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_cur       (pc_cur),
    .pc_next      (pc_next),
    .pc_we        (pc_we),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .exc_align    (exc_align),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: 0 boot, 1 fetching, 2 waiting on decoder, 3 resolving
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // entered at posedge+1, returns at the next posedge+1
  task automatic cyc(input logic ack, input logic [31:0] rd,
                     input logic rdy, input logic stl,
                     input logic jmp, input logic [31:0] jt,
                     input logic br,  input logic [31:0] bt);
    logic [31:0] e_next;
    logic [31:0] t;
    logic        e_we;
    logic        e_exc;
    pc_cur        = m_pc;
    imem_ack      = ack;
    imem_rdata    = rd;
    instr_ready   = rdy;
    stall         = stl;
    jump          = jmp;
    jump_target   = jt;
    branch_taken  = br;
    branch_target = bt;
    @(negedge clk);
    e_we   = 1'b0;
    e_next = '0;
    e_exc  = 1'b0;
    if (m_phase == 0) begin
      e_we   = 1'b1;
      e_next = RV;
    end else if (m_phase == 3 && !stl) begin
      e_we = 1'b1;
      if (jmp || br) begin
        t = jmp ? jt : bt;
        if (t % 4 != 0) begin
          e_next = EXC;
          e_exc  = 1'b1;
        end else begin
          e_next = t;
        end
      end else begin
        e_next = m_pc + 32'd4;
      end
    end
    chk("pc_we", pc_we, e_we);
    chk("pc_next", pc_next, e_next);
    chk("exc_align", exc_align, e_exc);
    chk("imem_req", imem_req, m_phase == 1);
    chk("imem_addr", imem_addr, (m_phase == 1) ? m_pc : 32'd0);
    chk("instr_valid", instr_valid, m_phase == 2);
    chk("instr", instr, m_instr);
    chk("retired", retired, m_ret);
    if (e_we) m_pc = e_next;
    case (m_phase)
      0: m_phase = 1;
      1: if (ack) begin m_instr = rd; m_phase = 2; end
      2: if (rdy) m_phase = 3;
      default: if (!stl) begin m_ret = m_ret + 1; m_phase = 1; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
  endtask

  // one full instruction with immediate ack and ready
  task automatic one(input logic [31:0] rd,
                     input logic jmp, input logic [31:0] jt,
                     input logic br,  input logic [31:0] bt);
    cyc(1, rd, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, jmp, jt, br, bt);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_instr = '0;
    m_ret   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pc_we", pc_we, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_req", imem_req, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic rnd_cycle();
    logic [31:0] jt;
    logic [31:0] bt;
    jt = $urandom;
    bt = $urandom;
    if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
    if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
    if ($urandom_range(9) == 0) jt = 32'hFFFF_FFFC;
    cyc($urandom_range(1), $urandom, $urandom_range(1),
        $urandom_range(9) < 3, $urandom_range(4) == 0, jt,
        $urandom_range(9) < 3, bt);
  endtask

  initial begin
    reset         = 1'b1;
    pc_cur        = '0;
    m_pc          = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    instr_ready   = 1'b0;
    stall         = 1'b0;
    jump          = 1'b0;
    jump_target   = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    idle();
    one(32'h2008_0005, 0, 0, 0, 0);
    repeat (5) idle();
    cyc(1, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 1, 32'h40, 1, 32'h80);
    cyc(0, 0, 0, 0, 1, 32'h40, 1, 32'h80);
    one(32'hAAAA_0001, 0, 0, 1, 32'h102);
    one(32'hAAAA_0002, 1, 32'hFFFF_FFFC, 0, 0);
    one(32'hAAAA_0003, 0, 0, 0, 0);
    one(32'hAAAA_0004, 1, 32'h0000_0041, 0, 0);

    repeat (600) rnd_cycle();

    for (int i = 0; i < 40 && m_phase != 2; i++)
      cyc(1, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0);
    chk("reach_issue", m_phase, 2);
    #1;
    chk("issue_valid", instr_valid, 1);
    do_reset();
    idle();
    one(32'h0BAD_F00D, 0, 0, 0, 0);
    repeat (100) rnd_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
